operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-to-execute operand stage of the CPU pipeline. Accepts one decoded instruction at a time and issues its source-register reads to the register file. Captures the registered read data, applies writeback forwarding and x0 forcing, then holds the operands until the execute stage accepts them. It is the sole driver of the register file read ports.

## Interface
Parameters:
- REG_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock; synchronous, active-high
- dec_valid  in  1  decoded instruction available
- dec_ready  out  1  stage accepts an instruction this cycle
- dec_rs1_en, dec_rs2_en  in  1 each  instruction reads rs1 / rs2
- dec_rs1, dec_rs2  in  REG_WIDTH each  source indices
- dec_rd  in  REG_WIDTH  destination index, passed through
- dec_rd_en  in  1  instruction writes rd, passed through
- rf_rs1_en, rf_rs2_en  out  1 each  register file read enables
- rf_rs1, rf_rs2  out  REG_WIDTH each  register file read indices
- rf_rs1_dout, rf_rs2_dout  in  DATA_WIDTH each  register file read data
- wb_en, wb_rd, wb_data  in  1 / REG_WIDTH / DATA_WIDTH  snoop of the register file write port
- ex_valid  out  1  operands valid
- ex_ready  in  1  execute accepts operands
- ex_rs1_data, ex_rs2_data  out  DATA_WIDTH each  operands
- ex_rd, ex_rd_en  out  REG_WIDTH / 1  passed-through destination

## Operation
Register file contract:
- Reads are registered, so data appears the cycle after the enable.
- A write (enable high and rd≠0) blocks any read in the same cycle; the read is dropped.
- rs2 is read only when rs1 is also enabled.

FSM states are IDLE, ISSUE, CAPTURE and HOLD.
- **IDLE**
  - dec_ready=1.
  - On dec_valid, latch all dec_* fields.
  - If neither rs enable is set, go to HOLD with both operands 0.
  - Otherwise go to ISSUE.
- **ISSUE**
  - rf_rs1_en=1.
  - rf_rs2_en=latched rs2_en.
  - rf_rs1 and rf_rs2 driven from the latched indices and stable for the whole cycle.
  - If wb_en && wb_rd≠0, the read is dropped: stay in ISSUE and retry next cycle.
  - Otherwise go to CAPTURE.
- **CAPTURE**
  - Register rf_*_dout into the operand registers, then go to HOLD.
  - Forwarding: if wb_en && wb_rd≠0 && wb_rd==rsN, operand N takes wb_data instead.
- **HOLD**
  - ex_valid=1.
  - Snoop writeback: same forwarding rule as CAPTURE, updating the held operand.
  - On ex_ready, go to IDLE.
- **Operand rules (all states)**
  - An operand whose index is 0 is always 0.
  - An operand whose enable is clear is always 0.
- rf_*_en are 0 outside ISSUE.
- dec_ready is 0 outside IDLE.

## Timing
- **Reset**
  - State goes to IDLE; ex_valid=0; operands, ex_rd and ex_rd_en are 0; rf_* outputs are 0.
  - dec_ready=0 while rst is high.
  - Reset mid-operation discards the in-flight instruction without emitting it.
- **Latency with no write conflict**
  - dec handshake in cycle N, ISSUE in N+1, CAPTURE in N+2, ex_valid from N+3.
  - Throughput is at most one instruction per 4 cycles.
- **No-operand instruction:** ex_valid at N+1.
- **Write conflict:** each cycle with a writeback during ISSUE adds one cycle.
- **Handshake rules**
  - ex_* outputs are stable while ex_valid && !ex_ready, except for forwarded operand updates.
  - ex_valid drops the cycle after ex_ready.
- **Forwarding timing:** a write in the CAPTURE or HOLD cycle updates the operand visible on the following cycle.

## Structure
- Shared cpu package holds:
  - the FSM state enum;
  - the constant REG_ZERO=0.
- One natural sub-module, operand_bypass:
  - combinational per-operand forward, x0 and enable mux;
  - instantiated twice.

## Test plan
- **Basic read:** preload x3=0x11, x4=0x22; issue rs1=3, rs2=4 → ex_valid 3 cycles after accept with ex_rs1_data=0x11, ex_rs2_data=0x22.
- **Write conflict:** wb_en=1, wb_rd=7 during ISSUE for 2 cycles → ISSUE repeats twice; operands are correct; ex_valid is 2 cycles later.
- **Forwarding in HOLD:** hold with ex_ready=0, rs1=5 (0xAA); write x5=0xBB → ex_rs1_data becomes 0xBB next cycle; rs2 is unchanged.
- **x0 behaviour:** rs1=0 with a concurrent wb_rd=0, wb_data=0xFF → ex_rs1_data=0.
- **Operand enables:** dec_rs2_en=0 → ex_rs2_data=0 and rf_rs2_en never asserts. Both enables 0 → ex_valid 1 cycle after accept.
- **Reset mid-operation:** rst in CAPTURE → next cycle ex_valid=0 and state is IDLE; dec_ready=1 once rst is low.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: FSM state encoding and the
// architectural zero-register index.
package operand_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } of_state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand select: x0/disabled forcing, writeback forwarding, else current value.
// Purely combinational, zero latency, no flow control.
module operand_bypass import operand_fetch_pkg::*; #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_en,
    input  logic [REG_WIDTH-1:0]  i_idx,
    input  logic [DATA_WIDTH-1:0] i_cur,
    input  logic                  i_wb_en,
    input  logic [REG_WIDTH-1:0]  i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic w_zero;
    logic w_fwd;

    assign w_zero = !i_en || (i_idx == REG_WIDTH'(REG_ZERO));
    // Writes to x0 are architecturally discarded, so they never forward.
    assign w_fwd  = i_wb_en && (i_wb_rd != REG_WIDTH'(REG_ZERO)) && (i_wb_rd == i_idx);
    assign o_data = w_zero ? '0 : (w_fwd ? i_wb_data : i_cur);

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: reads the register file, forwards writeback, holds operands.
// Latency 3 cycles (1 with no sources, +1 per write-blocked issue); holds operands until ex_ready.
module operand_fetch import operand_fetch_pkg::*; #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic                  dec_rs1_en,
    input  logic                  dec_rs2_en,
    input  logic [REG_WIDTH-1:0]  dec_rs1,
    input  logic [REG_WIDTH-1:0]  dec_rs2,
    input  logic [REG_WIDTH-1:0]  dec_rd,
    input  logic                  dec_rd_en,
    output logic                  rf_rs1_en,
    output logic                  rf_rs2_en,
    output logic [REG_WIDTH-1:0]  rf_rs1,
    output logic [REG_WIDTH-1:0]  rf_rs2,
    input  logic [DATA_WIDTH-1:0] rf_rs1_dout,
    input  logic [DATA_WIDTH-1:0] rf_rs2_dout,
    input  logic                  wb_en,
    input  logic [REG_WIDTH-1:0]  wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [REG_WIDTH-1:0]  ex_rd,
    output logic                  ex_rd_en
);

    of_state_e             r_state;
    logic                  r_dec_ready;
    logic                  r_rf_rs1_en;
    logic                  r_rf_rs2_en;
    logic                  r_ex_valid;
    logic [REG_WIDTH-1:0]  r_rs1;
    logic [REG_WIDTH-1:0]  r_rs2;
    logic [REG_WIDTH-1:0]  r_rd;
    logic                  r_rs1_en;
    logic                  r_rs2_en;
    logic                  r_rd_en;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [DATA_WIDTH-1:0] w_cur1;
    logic [DATA_WIDTH-1:0] w_cur2;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;
    logic                  w_wb_hit;

    // Any real register write steals the register file port this cycle.
    assign w_wb_hit = wb_en && (wb_rd != REG_WIDTH'(REG_ZERO));

    assign w_cur1 = (r_state == ST_CAPTURE) ? rf_rs1_dout : r_op1;
    assign w_cur2 = (r_state == ST_CAPTURE) ? rf_rs2_dout : r_op2;

    operand_bypass #(.REG_WIDTH(REG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bypass_rs1 (
        .i_en      (r_rs1_en),
        .i_idx     (r_rs1),
        .i_cur     (w_cur1),
        .i_wb_en   (wb_en),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_data    (w_op1)
    );

    operand_bypass #(.REG_WIDTH(REG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bypass_rs2 (
        .i_en      (r_rs2_en),
        .i_idx     (r_rs2),
        .i_cur     (w_cur2),
        .i_wb_en   (wb_en),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_data    (w_op2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dec_ready <= 1'b1;
            r_rf_rs1_en <= 1'b0;
            r_rf_rs2_en <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_en    <= 1'b0;
            r_rs2_en    <= 1'b0;
            r_rd_en     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dec_valid) begin
                        r_rs1       <= dec_rs1;
                        r_rs2       <= dec_rs2;
                        r_rd        <= dec_rd;
                        r_rs1_en    <= dec_rs1_en;
                        r_rs2_en    <= dec_rs2_en;
                        r_rd_en     <= dec_rd_en;
                        r_op1       <= '0;
                        r_op2       <= '0;
                        r_dec_ready <= 1'b0;
                        if (!dec_rs1_en && !dec_rs2_en) begin
                            r_state    <= ST_HOLD;
                            r_ex_valid <= 1'b1;
                        end else begin
                            // The register file only reads rs2 alongside rs1.
                            r_state     <= ST_ISSUE;
                            r_rf_rs1_en <= 1'b1;
                            r_rf_rs2_en <= dec_rs2_en;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!w_wb_hit) begin
                        r_state     <= ST_CAPTURE;
                        r_rf_rs1_en <= 1'b0;
                        r_rf_rs2_en <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_op1      <= w_op1;
                    r_op2      <= w_op2;
                    r_state    <= ST_HOLD;
                    r_ex_valid <= 1'b1;
                end
                ST_HOLD: begin
                    r_op1 <= w_op1;
                    r_op2 <= w_op2;
                    if (ex_ready) begin
                        r_state     <= ST_IDLE;
                        r_ex_valid  <= 1'b0;
                        r_dec_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dec_ready   = r_dec_ready && !rst;
    assign rf_rs1_en   = r_rf_rs1_en;
    assign rf_rs2_en   = r_rf_rs2_en;
    assign rf_rs1      = r_rf_rs1_en ? r_rs1 : '0;
    assign rf_rs2      = r_rf_rs2_en ? r_rs2 : '0;
    assign ex_valid    = r_ex_valid;
    assign ex_rs1_data = r_op1;
    assign ex_rs2_data = r_op2;
    assign ex_rd       = r_rd;
    assign ex_rd_en    = r_rd_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model plus architectural register array
// as reference; operands must always equal the current architectural values.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready, dec_rs1_en, dec_rs2_en, dec_rd_en;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        rf_rs1_en, rf_rs2_en;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_dout, rf_rs2_dout;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready, ex_rd_en;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rd;

    logic [31:0] regs [0:31] = '{default: '0};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_rd_en(dec_rd_en),
        .rf_rs1_en(rf_rs1_en), .rf_rs2_en(rf_rs2_en),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_rd_en(ex_rd_en)
    );

    // Register file: registered reads, a write to a nonzero rd drops that cycle's reads.
    // Dropped or disabled reads return junk so a missed retry cannot go unnoticed.
    always @(posedge clk) begin
        if (wb_en && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
        if (rf_rs1_en && !(wb_en && wb_rd != 5'd0)) rf_rs1_dout <= regs[rf_rs1];
        else rf_rs1_dout <= $urandom;
        if (rf_rs2_en && !(wb_en && wb_rd != 5'd0)) rf_rs2_dout <= regs[rf_rs2];
        else rf_rs2_dout <= $urandom;
    end

    function automatic logic [31:0] exp_op(input logic en, input logic [4:0] idx);
        return (en && idx != 5'd0) ? regs[idx] : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic accept();
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
    endtask

    // Handshakes one instruction and waits for ex_valid. n_conf writes to conf_rd are
    // injected in ISSUE cycles; cap_wr writes a random value to rs1 in the CAPTURE cycle.
    task automatic send_instr(input logic r1e, input logic [4:0] r1,
                              input logic r2e, input logic [4:0] r2,
                              input logic [4:0] rd, input logic rde,
                              input int n_conf, input logic [4:0] conf_rd, input bit cap_wr,
                              output int lat, output int n_issue, output bit rs2_seen,
                              output bit timed_out);
        int  guard;
        bit  prev_issue;
        guard = 0; prev_issue = 0; lat = 0; n_issue = 0; rs2_seen = 0; timed_out = 0;
        while (!dec_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!dec_ready) begin
            timed_out = 1;
            return;
        end
        dec_rs1_en = r1e; dec_rs1 = r1; dec_rs2_en = r2e; dec_rs2 = r2;
        dec_rd = rd; dec_rd_en = rde; dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
        lat = 1;
        while (!ex_valid && lat < 40) begin
            if (rf_rs2_en) rs2_seen = 1;
            if (rf_rs1_en) n_issue++;
            if (rf_rs1_en && n_conf > 0) begin
                wb_en = 1'b1; wb_rd = conf_rd; wb_data = $urandom;
                n_conf--;
            end else if (!rf_rs1_en && prev_issue && cap_wr) begin
                wb_en = 1'b1; wb_rd = r1; wb_data = $urandom;
            end
            prev_issue = rf_rs1_en;
            tick();
            wb_en = 1'b0;
            lat++;
        end
        if (!ex_valid) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready: got %b want 0", dec_ready); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        checks++; if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0) begin errors++; $display("FAIL reset_operands: got %h %h want 0 0", ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_rd !== 5'd0 || ex_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd: got %0d/%b want 0/0", ex_rd, ex_rd_en); end
        checks++; if ({rf_rs1_en, rf_rs2_en, rf_rs1, rf_rs2} !== 12'd0) begin errors++; $display("FAIL reset_rf: got %b %b %0d %0d want all 0", rf_rs1_en, rf_rs2_en, rf_rs1, rf_rs2); end
        rst = 1'b0;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", dec_ready); end
    endtask

    task automatic test_basic_read();
        int lat, ni; bit s2, to;
        wb_write(5'd3, 32'h11);
        wb_write(5'd4, 32'h22);
        send_instr(1, 5'd3, 1, 5'd4, 5'd9, 1, 0, 5'd0, 0, lat, ni, s2, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: no ex_valid"); end
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
        checks++; if (ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'h22) begin errors++; $display("FAIL basic_data: got %h %h want 11 22", ex_rs1_data, ex_rs2_data); end
        checks++; if (ex_rd !== 5'd9 || ex_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd: got %0d/%b want 9/1", ex_rd, ex_rd_en); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'h11 || ex_rd !== 5'd9) begin errors++; $display("FAIL basic_stable: got v=%b %h rd=%0d want 1 11 9", ex_valid, ex_rs1_data, ex_rd); end
        accept();
        checks++; if (ex_valid !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got v=%b rdy=%b want 0 1", ex_valid, dec_ready); end
    endtask

    task automatic test_write_conflict();
        int lat, ni; bit s2, to;
        send_instr(1, 5'd3, 1, 5'd7, 5'd1, 1, 2, 5'd7, 0, lat, ni, s2, to);
        checks++; if (to) begin errors++; $display("FAIL conflict_timeout: no ex_valid"); end
        checks++; if (lat != 5) begin errors++; $display("FAIL conflict_latency: got %0d want 5", lat); end
        checks++; if (ni != 3) begin errors++; $display("FAIL conflict_issue_cycles: got %0d want 3", ni); end
        checks++; if (ex_rs1_data !== 32'h11 || ex_rs2_data !== regs[7]) begin errors++; $display("FAIL conflict_data: got %h %h want 11 %h", ex_rs1_data, ex_rs2_data, regs[7]); end
        accept();
    endtask

    task automatic test_forwarding();
        int lat, ni; bit s2, to;
        wb_write(5'd5, 32'hAA);
        send_instr(1, 5'd5, 1, 5'd4, 5'd2, 0, 0, 5'd0, 0, lat, ni, s2, to);
        checks++; if (to || ex_rs1_data !== 32'hAA) begin errors++; $display("FAIL hold_fwd_before: got to=%b %h want 0 aa", to, ex_rs1_data); end
        wb_write(5'd5, 32'hBB);
        checks++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'hBB || ex_rs2_data !== 32'h22) begin errors++; $display("FAIL hold_fwd_after: got v=%b %h %h want 1 bb 22", ex_valid, ex_rs1_data, ex_rs2_data); end
        accept();
        send_instr(1, 5'd5, 1, 5'd5, 5'd2, 0, 0, 5'd0, 1, lat, ni, s2, to);
        checks++; if (to || ex_rs1_data !== exp_op(1, 5'd5) || ex_rs2_data !== exp_op(1, 5'd5)) begin errors++; $display("FAIL capture_fwd: got %h %h want %h", ex_rs1_data, ex_rs2_data, exp_op(1, 5'd5)); end
        accept();
    endtask

    task automatic test_x0();
        int lat, ni; bit s2, to;
        send_instr(1, 5'd0, 1, 5'd4, 5'd0, 0, 2, 5'd0, 0, lat, ni, s2, to);
        checks++; if (to || lat != 3) begin errors++; $display("FAIL x0_no_conflict_latency: got %0d want 3", lat); end
        wb_write(5'd0, 32'hFF);
        checks++; if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'h22) begin errors++; $display("FAIL x0_data: got %h %h want 0 22", ex_rs1_data, ex_rs2_data); end
        accept();
    endtask

    task automatic test_enables();
        int lat, ni; bit s2, to;
        send_instr(1, 5'd3, 0, 5'd4, 5'd6, 1, 0, 5'd0, 0, lat, ni, s2, to);
        checks++; if (to || ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'd0) begin errors++; $display("FAIL rs2_disabled_data: got %h %h want 11 0", ex_rs1_data, ex_rs2_data); end
        checks++; if (s2) begin errors++; $display("FAIL rs2_disabled_rf_en: got rf_rs2_en=1 want never"); end
        accept();
        send_instr(0, 5'd3, 0, 5'd4, 5'd6, 1, 0, 5'd0, 0, lat, ni, s2, to);
        checks++; if (to || lat != 1) begin errors++; $display("FAIL no_operand_latency: got %0d want 1", lat); end
        checks++; if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0 || ni != 0) begin errors++; $display("FAIL no_operand_data: got %h %h issues=%0d want 0 0 0", ex_rs1_data, ex_rs2_data, ni); end
        accept();
    endtask

    task automatic test_reset_mid();
        dec_rs1_en = 1; dec_rs1 = 5'd3; dec_rs2_en = 1; dec_rs2 = 5'd4;
        dec_rd = 5'd8; dec_rd_en = 1; dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        checks++; if (rf_rs1_en !== 1'b1 || rf_rs1 !== 5'd3 || rf_rs2 !== 5'd4) begin errors++; $display("FAIL midrst_issue: got %b %0d %0d want 1 3 4", rf_rs1_en, rf_rs1, rf_rs2); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || dec_ready !== 1'b0) begin errors++; $display("FAIL midrst_during: got v=%b rdy=%b want 0 0", ex_valid, dec_ready); end
        rst = 1'b0;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", dec_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || rf_rs1_en !== 1'b0) begin errors++; $display("FAIL midrst_discard: got v=%b rf=%b want 0 0", ex_valid, rf_rs1_en); end
    endtask

    task automatic test_random();
        int lat, ni, nc, hold, exp_lat; bit s2, to, cw;
        logic r1e, r2e, rde;
        logic [4:0] r1, r2, rd, crd;
        for (int i = 0; i < 40; i++) begin
            r1e = ($urandom_range(0, 3) != 0); r2e = ($urandom_range(0, 3) != 0);
            r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom); rde = 1'($urandom);
            nc = $urandom_range(0, 2); crd = 5'($urandom_range(0, 7)); cw = 1'($urandom);
            send_instr(r1e, r1, r2e, r2, rd, rde, nc, crd, cw, lat, ni, s2, to);
            exp_lat = (!r1e && !r2e) ? 1 : 3 + ((crd != 5'd0) ? nc : 0);
            checks++; if (to || lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
            checks++; if (ex_rs1_data !== exp_op(r1e, r1) || ex_rs2_data !== exp_op(r2e, r2)) begin errors++; $display("FAIL rand_data[%0d]: got %h %h want %h %h", i, ex_rs1_data, ex_rs2_data, exp_op(r1e, r1), exp_op(r2e, r2)); end
            checks++; if (ex_rd !== rd || ex_rd_en !== rde) begin errors++; $display("FAIL rand_rd[%0d]: got %0d/%b want %0d/%b", i, ex_rd, ex_rd_en, rd, rde); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 1) == 1) wb_write(5'($urandom_range(0, 7)), $urandom);
                else tick();
                checks++; if (ex_valid !== 1'b1 || ex_rs1_data !== exp_op(r1e, r1) || ex_rs2_data !== exp_op(r2e, r2)) begin errors++; $display("FAIL rand_hold[%0d]: got v=%b %h %h want 1 %h %h", i, ex_valid, ex_rs1_data, ex_rs2_data, exp_op(r1e, r1), exp_op(r2e, r2)); end
            end
            accept();
            checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rand_release[%0d]: got %b want 0", i, ex_valid); end
        end
    endtask

    initial begin
        rst = 1'b1; dec_valid = 0; dec_rs1_en = 0; dec_rs2_en = 0; dec_rs1 = 0; dec_rs2 = 0;
        dec_rd = 0; dec_rd_en = 0; wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
        test_reset();
        test_basic_read();
        test_write_conflict();
        test_forwarding();
        test_x0();
        test_enables();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
